// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared M-extension funct3 codes, FSM encoding and width defaults
package ex_muldiv_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: iterative shift-add multiplier and restoring divider with sign fixup
module muldiv_core import ex_muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            bypass,
  output logic [XLEN-1:0] result
);
  localparam logic [XLEN-1:0] HI = {XLEN{1'b1}} << 32;
  localparam logic [XLEN-1:0] MSB = {1'b1, {(XLEN-1){1'b0}}};
  logic sa, sb, a_neg, b_neg, dz, ovf, ge;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_n, qs, rs, raw;
  logic [XLEN:0] r_sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [2:0] f3;
  logic w, neg_p, neg_r, dz_r, ovf_r;
  logic [XLEN-1:0] a_sv, mq, quo, rem;
  logic [2*XLEN-1:0] acc, mc;
  always_comb begin
    sa = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sb = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    a_neg = sa && (word ? rs1[31] : rs1[XLEN-1]);
    b_neg = sb && (word ? rs2[31] : rs2[XLEN-1]);
    a_ext = word ? (rs1 & ~HI) | (a_neg ? HI : '0) : rs1;
    b_ext = word ? (rs2 & ~HI) | (b_neg ? HI : '0) : rs2;
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;
    min_n = word ? HI | XLEN'(32'h8000_0000) : MSB;
    dz = funct3[2] && b_ext == '0;
    ovf = funct3[2] && sb && a_ext == min_n && b_ext == '1;
    bypass = dz || ovf;
    r_sh = {rem, quo[XLEN-1]};
    diff = r_sh - {1'b0, mq};
    ge = !diff[XLEN];
    prod = neg_p ? -acc : acc;
    qs = neg_p ? -quo : quo;
    rs = neg_r ? -rem : rem;
    raw = dz_r ? (f3[1] ? a_sv : '1) :
          ovf_r ? (f3[1] ? '0 : a_sv) :
          f3[2] ? (f3[1] ? rs : qs) :
          f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    result = w ? (raw & ~HI) | (raw[31] ? HI : '0) : raw;
  end
  // W dividends are left-aligned so the quotient lands in the low 32 bits after 32 steps
  always_ff @(posedge clk) begin
    if (rst) begin
      f3 <= '0;
      w <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz_r <= 1'b0;
      ovf_r <= 1'b0;
      a_sv <= '0;
      mq <= '0;
      quo <= '0;
      rem <= '0;
      acc <= '0;
      mc <= '0;
    end else if (start) begin
      f3 <= funct3;
      w <= word;
      neg_p <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dz_r <= dz;
      ovf_r <= ovf;
      a_sv <= a_ext;
      mq <= abs_b;
      quo <= word ? abs_a << (XLEN-32) : abs_a;
      rem <= '0;
      acc <= '0;
      mc <= {{XLEN{1'b0}}, abs_a};
    end else if (step && f3[2]) begin
      rem <= ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
      quo <= {quo[XLEN-2:0], ge};
    end else if (step) begin
      acc <= mq[0] ? acc + mc : acc;
      mc <= mc << 1;
      mq <= mq >> 1;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV M-extension execute unit; FSM, iteration counter and result/tag registers
module ex_muldiv import ex_muldiv_pkg::*; #(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            funct3_i,
  input  logic                  word_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       wdata_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  wreg_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(XLEN) + 1;
  state_t state, state_n;
  logic accept, bypass;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] result;
  assign ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign valid_o = state == DONE;
  assign accept = valid_i && ready_o && !flush_i;
  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk(clk),
    .rst(rst),
    .start(accept),
    .step(state == CALC),
    .funct3(funct3_i),
    .word(word_i),
    .rs1(rs1_data_i),
    .rs2(rs2_data_i),
    .bypass(bypass),
    .result(result)
  );
  always_comb begin
    state_n = state;
    state_n = flush_i ? IDLE :
              state == IDLE ? (accept ? (bypass ? FIXUP : CALC) : IDLE) :
              state == CALC ? (cnt == CW'(1) ? FIXUP : CALC) :
              state == FIXUP ? DONE :
              ready_i ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wdata_o <= '0;
      rd_addr_o <= '0;
      wreg_o <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= word_i ? CW'(32) : CW'(XLEN);
        rd_addr_o <= rd_addr_i;
        wreg_o <= wreg_i;
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
      end
      if (state == FIXUP && !flush_i) wdata_o <= result;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv (XLEN=64) with hand-computed results and latencies
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, word_i = 1'b0, wreg_i = 1'b0;
  logic flush_i = 1'b0, ready_i = 1'b1;
  logic ready_o, valid_o, wreg_o, busy_o;
  logic [2:0] funct3_i = '0;
  logic [63:0] rs1_data_i = '0, rs2_data_i = '0, wdata_o;
  logic [4:0] rd_addr_i = '0, rd_addr_o;
  int checks = 0, errors = 0;
  ex_muldiv #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .funct3_i(funct3_i),
    .word_i(word_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .wreg_i(wreg_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .wdata_o(wdata_o),
    .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Offer one op with input scrambling after accept; valid_o is first seen n+1 edges after the
  // accept edge (cycle N+n+2), so edges is 65 for 64-bit, 33 for W and 1 for bypassed divides.
  task automatic op(input string tag, input logic [2:0] f3, input logic w, input logic [63:0] a,
                    input logic [63:0] b, input logic [4:0] rd, input logic wr, input int edges,
                    input logic [63:0] exp);
    int lat;
    funct3_i = f3; word_i = w; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; wreg_i = wr;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; funct3_i = ~f3; rs1_data_i = ~a; rs2_data_i = ~b; rd_addr_i = ~rd; wreg_i = ~wr;
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(edges));
    check({tag, ".data"}, wdata_o, exp);
    check({tag, ".tag"}, {58'b0, wreg_o, rd_addr_o}, {58'b0, wr, rd});
    @(posedge clk); #1;
    check({tag, ".idle"}, {62'b0, valid_o, ready_o}, 64'b01);
  endtask
  initial begin
    logic seen;
    int lat;
    logic [63:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", {63'b0, valid_o}, 64'd0);
    check("rst.busy", {63'b0, busy_o}, 64'd0);
    check("rst.wdata", wdata_o, 64'd0);
    check("rst.tag", {58'b0, wreg_o, rd_addr_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.ready", {63'b0, ready_o}, 64'd1);
    op("mul", F3_MUL, 0, 64'd7, -64'sd3, 5'd5, 1, 65, 64'hFFFF_FFFF_FFFF_FFEB);
    op("mulhu", F3_MULHU, 0, '1, '1, 5'd6, 1, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    op("div0", F3_DIV, 0, -64'sd20, 64'd0, 5'd7, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    op("rem0", F3_REM, 0, -64'sd20, 64'd0, 5'd8, 0, 1, 64'hFFFF_FFFF_FFFF_FFEC);
    op("divw_ovf", F3_DIV, 1, 64'h8000_0000, '1, 5'd9, 1, 1, 64'hFFFF_FFFF_8000_0000);
    op("remw_ovf", F3_REM, 1, 64'h8000_0000, '1, 5'd10, 1, 1, 64'd0);
    op("div", F3_DIV, 0, -64'sd20, 64'd3, 5'd11, 1, 65, 64'hFFFF_FFFF_FFFF_FFFA);
    op("rem", F3_REM, 0, -64'sd20, 64'd3, 5'd12, 1, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    op("mulw", F3_MUL, 1, 64'h7FFF_FFFF, 64'd2, 5'd13, 1, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    op("mulh", F3_MULH, 0, '1, '1, 5'd14, 1, 65, 64'd0);
    op("mulhsu", F3_MULHSU, 0, '1, 64'd2, 5'd15, 1, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    op("divuw", F3_DIVU, 1, 64'd100, 64'd7, 5'd16, 1, 33, 64'd14);
    op("remu", F3_REMU, 0, 64'd100, 64'd7, 5'd17, 1, 65, 64'd2);
    funct3_i = F3_DIVU; word_i = 1'b0; rs1_data_i = 64'd1000; rs2_data_i = 64'd10;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush.busy_before", {63'b0, busy_o}, 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush.idle", {61'b0, valid_o, busy_o, ready_o}, 64'b001);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      seen = seen | valid_o;
    end
    check("flush.no_result", {63'b0, seen}, 64'd0);
    op("divu_after_flush", F3_DIVU, 0, 64'd1000, 64'd10, 5'd3, 1, 65, 64'd100);
    funct3_i = F3_MUL; rs1_data_i = 64'd2; rs2_data_i = 64'd2; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_accept.dropped", {62'b0, busy_o, ready_o}, 64'b01);
    ready_i = 1'b0;
    funct3_i = F3_MUL; rs1_data_i = 64'd6; rs2_data_i = 64'd7; rd_addr_i = 5'd9; wreg_i = 1'b0;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; rs1_data_i = 64'd9; rd_addr_i = 5'd1; wreg_i = 1'b1;
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold.lat", 64'(lat), 64'd65);
    held = wdata_o;
    check("hold.data", held, 64'd42);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold.data_stable", wdata_o, 64'd42);
      check("hold.ctl", {56'b0, valid_o, ready_o, wreg_o, rd_addr_o}, {56'b0, 1'b1, 1'b0, 1'b0, 5'd9});
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (10) begin
      seen = seen | valid_o;
      @(posedge clk); #1;
    end
    check("hold.one_result", {62'b0, seen, ready_o}, 64'b01);
    funct3_i = F3_MUL; rs1_data_i = 64'd3; rs2_data_i = 64'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_inflight.state", {62'b0, valid_o, busy_o}, 64'd0);
    check("rst_inflight.wdata", wdata_o, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  operation offered.
REQ-006 SHALL have port ready_o  output  1  unit can accept.
REQ-007 SHALL have port funct3_i  input  3  RV M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port word_i  input  1  W-variant (opcode word type), legal only when XLEN=64.
REQ-009 SHALL have port rs1_data_i  input  XLEN  operand A, already forwarded.
REQ-010 SHALL have port rs2_data_i  input  XLEN  operand B, already forwarded.
REQ-011 SHALL have port rd_addr_i  input  REG_ADDR_W  destination tag.
REQ-012 SHALL have port wreg_i  input  1  write-enable tag.
REQ-013 SHALL have port flush_i  input  1  kill the in-flight operation.
REQ-014 SHALL have port valid_o  output  1  result available.
REQ-015 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-016 SHALL have port wdata_o  output  XLEN  result.
REQ-017 SHALL have port rd_addr_o  output  REG_ADDR_W  captured tag.
REQ-018 SHALL have port wreg_o  output  1  captured write-enable.
REQ-019 SHALL have port busy_o  output  1  high in any state other than IDLE; drives the pipeline stall.

Function
REQ-020 SHALL implement the FSM IDLE -> CALC -> FIXUP -> DONE -> IDLE.
REQ-021 SHALL assert ready_o only in IDLE; an accept is valid_i && ready_o at a rising edge.
REQ-022 SHALL capture operands, funct3, word, rd_addr_i and wreg_i on accept; later changes on these inputs SHALL be ignored.
REQ-023 SHALL set the operation width n to 32 when word_i=1, else XLEN; W operands use bits [31:0], sign- or zero-extended per funct3.
REQ-024 SHALL take operand absolute values in the accept cycle for signed ops; MULHSU treats rs2 as unsigned.
REQ-025 SHALL, in CALC, process one bit per cycle (shift-add multiply, restoring divide) for exactly n cycles, using a counter of width clog2(XLEN)+1.
REQ-026 SHALL, in FIXUP, apply sign correction and select the low/high product, quotient or remainder, sign-extending W results from bit 31.
REQ-027 SHALL hold valid_o=1 and stable outputs in DONE until ready_i=1, then return to IDLE on the same edge.
REQ-028 SHALL give latency accept edge N -> valid_o high from cycle N+n+2 (N+66 for XLEN=64 non-W, N+34 for W).
REQ-029 SHALL, on divide-by-zero, bypass CALC (accept -> FIXUP): quotient all-ones (after W extension), remainder = dividend; valid_o from N+2.
REQ-030 SHALL, on signed overflow (dividend = most-negative of width n, divisor = -1), bypass CALC: quotient = dividend, remainder 0; valid_o from N+2.
REQ-031 SHALL, on flush_i=1 in any state, return to IDLE at the next edge with valid_o=0 and no result delivered.
REQ-032 SHALL give flush_i priority over an accept in the same cycle; the offered operation is dropped.
REQ-033 SHALL not accept a new operation on the edge that leaves DONE; back-to-back operations need one IDLE cycle.
REQ-034 SHALL compute all arithmetic modulo 2^XLEN, with a 2*XLEN product internally.

Reset
REQ-035 SHALL, while rst=1, force state IDLE, counter 0, valid_o 0, busy_o 0, wdata_o 0, rd_addr_o 0, wreg_o 0; ready_o=1 in the cycle after rst deasserts.
REQ-036 SHALL give rst priority over flush_i and valid_i; an operation in flight is discarded.

Structure
REQ-037 SHALL place funct3 M-codes, FSM state encoding and the XLEN default in the shared defines.
REQ-038 SHALL use one sub-module, muldiv_core (iterative shift/subtract datapath), with the FSM and tag registers in ex_muldiv.

Verification
REQ-039 SHALL verify MUL, rs1=7, rs2=-3, XLEN=64 -> wdata_o=0xFFFFFFFFFFFFFFEB, valid_o at N+66.
REQ-040 SHALL verify MULHU, rs1=rs2=0xFFFFFFFFFFFFFFFF -> wdata_o=0xFFFFFFFFFFFFFFFE.
REQ-041 SHALL verify DIV, rs1=-20, rs2=0 -> wdata_o all-ones at N+2; REM with the same operands -> wdata_o=-20.
REQ-042 SHALL verify DIVW, rs1=0x80000000, rs2=-1 -> wdata_o=0xFFFFFFFF80000000; REMW -> 0.
REQ-043 SHALL verify flush_i pulsed at cycle N+10 of a DIVU -> IDLE at N+11, valid_o never asserted, next op accepted correctly.
REQ-044 SHALL verify ready_i held low 5 cycles in DONE -> wdata_o, rd_addr_o and wreg_o stable, ready_o low, one result only.
